// File: rtl/rtc_pkg.sv
// Shared types, limits and calendar helpers for the RTC calendar core.
package rtc_pkg;

    typedef enum logic [1:0] {StIdle, StCheck, StApply, StReject} set_state_e;

    localparam logic [5:0] SEC_MAX   = 6'd59;
    localparam logic [5:0] MIN_MAX   = 6'd59;
    localparam logic [4:0] HOUR_MAX  = 5'd23;
    localparam logic [3:0] MONTH_MAX = 4'd12;

    // Years 2000..2099 only, so the century exception never applies.
    function automatic logic is_leap(input logic [1:0] year_lsb);
        return year_lsb == 2'd0;
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic [1:0] year_lsb);
        logic [4:0] days;
        case (month)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: days = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    days = 5'd30;
            4'd2:    days = is_leap(year_lsb) ? 5'd29 : 5'd28;
            default: days = 5'd0;
        endcase
        return days;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the system clock down to a one-cycle 1 Hz strobe.
module rtc_prescaler #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned     CntW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_HZ - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_calendar_core.sv
// Calendar RTC: 1 Hz timekeeping with month lengths and leap years, a validated
// set-time handshake and a 12/24-hour display mapping.
module rtc_calendar_core
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned YEAR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              mode_12h,
    input  logic              set_valid,
    output logic              set_ready,
    input  logic [5:0]        set_sec,
    input  logic [5:0]        set_min,
    input  logic [4:0]        set_hour,
    input  logic [4:0]        set_day,
    input  logic [3:0]        set_month,
    input  logic [YEAR_W-1:0] set_year,
    output logic              set_err,
    output logic [5:0]        second,
    output logic [5:0]        minute,
    output logic [4:0]        hour,
    output logic [4:0]        disp_hour,
    output logic              pm,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              tick_1hz,
    output logic              day_roll,
    output logic              year_wrap
);
    localparam logic [YEAR_W-1:0] YearLast = YEAR_W'(99);

    set_state_e        state_q, state_d;
    logic              capture, set_ok, applying, pre_tick;
    logic [5:0]        cap_sec_q, cap_min_q;
    logic [4:0]        cap_hour_q, cap_day_q;
    logic [3:0]        cap_month_q;
    logic [YEAR_W-1:0] cap_year_q;

    logic [5:0]        sec_q, sec_d, min_q, min_d;
    logic [4:0]        hour_q, hour_d, day_q, day_d;
    logic [3:0]        month_q, month_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic              tick_q, tick_d, roll_q, roll_d, wrap_q, wrap_d;

    // Loading a new time restarts the second from a clean prescaler phase.
    rtc_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (applying),
        .tick (pre_tick)
    );

    assign set_ok = (cap_sec_q <= SEC_MAX) && (cap_min_q <= MIN_MAX) &&
                    (cap_hour_q <= HOUR_MAX) &&
                    (cap_month_q != 4'd0) && (cap_month_q <= MONTH_MAX) &&
                    (cap_day_q != 5'd0) &&
                    (cap_day_q <= days_in_month(cap_month_q, cap_year_q[1:0]));

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        set_ready = 1'b0;
        set_err   = 1'b0;
        applying  = 1'b0;
        unique case (state_q)
            StIdle: begin
                set_ready = 1'b1;
                if (set_valid) begin
                    state_d = StCheck;
                    capture = 1'b1;
                end
            end
            StCheck:  state_d = set_ok ? StApply : StReject;
            StApply: begin
                applying = 1'b1;
                state_d  = StIdle;
            end
            StReject: begin
                set_err = 1'b1;
                state_d = StIdle;
            end
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        tick_d  = 1'b0;
        roll_d  = 1'b0;
        wrap_d  = 1'b0;
        if (applying) begin
            sec_d   = cap_sec_q;
            min_d   = cap_min_q;
            hour_d  = cap_hour_q;
            day_d   = cap_day_q;
            month_d = cap_month_q;
            year_d  = cap_year_q;
        end else if (pre_tick) begin
            tick_d = 1'b1;
            sec_d  = sec_q + 6'd1;
            if (sec_q == SEC_MAX) begin
                sec_d = 6'd0;
                min_d = min_q + 6'd1;
                if (min_q == MIN_MAX) begin
                    min_d  = 6'd0;
                    hour_d = hour_q + 5'd1;
                    if (hour_q == HOUR_MAX) begin
                        hour_d = 5'd0;
                        roll_d = 1'b1;
                        day_d  = day_q + 5'd1;
                        if (day_q >= days_in_month(month_q, year_q[1:0])) begin
                            day_d   = 5'd1;
                            month_d = month_q + 4'd1;
                            if (month_q >= MONTH_MAX) begin
                                month_d = 4'd1;
                                year_d  = year_q + YEAR_W'(1);
                                if (year_q == YearLast) begin
                                    year_d = '0;
                                    wrap_d = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            cap_sec_q   <= set_sec;
            cap_min_q   <= set_min;
            cap_hour_q  <= set_hour;
            cap_day_q   <= set_day;
            cap_month_q <= set_month;
            cap_year_q  <= set_year;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hour_q  <= 5'd0;
            day_q   <= 5'd1;
            month_q <= 4'd1;
            year_q  <= '0;
            tick_q  <= 1'b0;
            roll_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            tick_q  <= tick_d;
            roll_q  <= roll_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        disp_hour = hour_q;
        if (mode_12h) begin
            if (hour_q == 5'd0) begin
                disp_hour = 5'd12;
            end else if (hour_q > 5'd12) begin
                disp_hour = hour_q - 5'd12;
            end
        end
    end

    assign pm        = hour_q >= 5'd12;
    assign second    = sec_q;
    assign minute    = min_q;
    assign hour      = hour_q;
    assign day       = day_q;
    assign month     = month_q;
    assign year      = year_q;
    assign tick_1hz  = tick_q;
    assign day_roll  = roll_q;
    assign year_wrap = wrap_q;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Self-checking bench for rtc_calendar_core: directed corners, a 12-hour
// mapping table and randomized traffic against a calendar reference model.
module tb_rtc_calendar_core;
    localparam int unsigned CLK_HZ = 4;
    localparam int unsigned YEAR_W = 7;

    logic              clk = 1'b0;
    logic              rst, run, mode_12h, set_valid;
    logic              set_ready, set_err, pm, tick_1hz, day_roll, year_wrap;
    logic [5:0]        set_sec, set_min, second, minute;
    logic [4:0]        set_hour, set_day, hour, disp_hour, day;
    logic [3:0]        set_month, month;
    logic [YEAR_W-1:0] set_year, year;

    rtc_calendar_core #(.CLK_HZ(CLK_HZ), .YEAR_W(YEAR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mode_12h  (mode_12h),
        .set_valid (set_valid),
        .set_ready (set_ready),
        .set_sec   (set_sec),
        .set_min   (set_min),
        .set_hour  (set_hour),
        .set_day   (set_day),
        .set_month (set_month),
        .set_year  (set_year),
        .set_err   (set_err),
        .second    (second),
        .minute    (minute),
        .hour      (hour),
        .disp_hour (disp_hour),
        .pm        (pm),
        .day       (day),
        .month     (month),
        .year      (year),
        .tick_1hz  (tick_1hz),
        .day_roll  (day_roll),
        .year_wrap (year_wrap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ticks = 0;

    // Reference model: time of day, date, prescaler phase and handshake stage
    // (0 idle, 1 checking, 2 applying or rejecting).
    int m_s, m_mi, m_h, m_d, m_mo, m_y, m_cnt, m_stage;
    int r_s, r_mi, r_h, r_d, r_mo, r_y;
    bit m_tick, m_roll, m_wrap;

    typedef struct {
        int hour;
        bit mode;
        int disp;
        bit pm;
    } vec_t;
    vec_t vecs[8];

    int rs, rmi, rh, rd, rmo, ry, waited;
    bit err_seen;

    function automatic int dim(int mo, int y);
        if (mo == 2) return (y % 4 == 0) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        if (mo >= 1 && mo <= 12) return 31;
        return 0;
    endfunction

    function automatic bit req_ok();
        return r_s <= 59 && r_mi <= 59 && r_h <= 23 && r_mo >= 1 && r_mo <= 12 &&
               r_d >= 1 && r_d <= dim(r_mo, r_y);
    endfunction

    task automatic advance_second();
        int tod;
        tod = m_h * 3600 + m_mi * 60 + m_s + 1;
        if (tod == 86400) begin
            tod    = 0;
            m_roll = 1;
            m_d++;
            if (m_d > dim(m_mo, m_y)) begin
                m_d = 1;
                m_mo++;
                if (m_mo > 12) begin
                    m_mo = 1;
                    m_y  = (m_y + 1) % 100;
                    if (m_y == 0) m_wrap = 1;
                end
            end
        end
        m_h  = tod / 3600;
        m_mi = (tod / 60) % 60;
        m_s  = tod % 60;
    endtask

    // Predicts the state right after the coming clock edge from current inputs.
    task automatic model_edge();
        bit applying, wrapped;
        m_tick = 0;
        m_roll = 0;
        m_wrap = 0;
        if (rst) begin
            m_s = 0; m_mi = 0; m_h = 0; m_d = 1; m_mo = 1; m_y = 0;
            m_cnt = 0; m_stage = 0;
            return;
        end
        applying = (m_stage == 2) && req_ok();
        wrapped  = run && (m_cnt == CLK_HZ - 1);
        if (run) m_cnt = (m_cnt + 1) % CLK_HZ;
        if (applying) begin
            m_s = r_s; m_mi = r_mi; m_h = r_h; m_d = r_d; m_mo = r_mo; m_y = r_y;
            m_cnt = 0;
        end else if (wrapped) begin
            m_tick = 1;
            advance_second();
        end
        case (m_stage)
            0: if (set_valid) begin
                r_s = int'(set_sec); r_mi = int'(set_min); r_h = int'(set_hour);
                r_d = int'(set_day); r_mo = int'(set_month); r_y = int'(set_year);
                m_stage = 1;
            end
            1: m_stage = 2;
            default: m_stage = 0;
        endcase
    endtask

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int exp_disp;
        exp_disp = m_h;
        if (mode_12h) exp_disp = (m_h == 0) ? 12 : ((m_h > 12) ? m_h - 12 : m_h);
        chk("second", int'(second), m_s);
        chk("minute", int'(minute), m_mi);
        chk("hour", int'(hour), m_h);
        chk("day", int'(day), m_d);
        chk("month", int'(month), m_mo);
        chk("year", int'(year), m_y);
        chk("tick_1hz", int'(tick_1hz), int'(m_tick));
        chk("day_roll", int'(day_roll), int'(m_roll));
        chk("year_wrap", int'(year_wrap), int'(m_wrap));
        chk("set_ready", int'(set_ready), int'(m_stage == 0));
        chk("set_err", int'(set_err), int'(m_stage == 2 && !req_ok()));
        chk("disp_hour", int'(disp_hour), exp_disp);
        chk("pm", int'(pm), int'(m_h >= 12));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        if (tick_1hz === 1'b1) n_ticks++;
        check_outputs();
    endtask

    task automatic drive_set(int s, int mi, int h, int d, int mo, int y);
        set_sec   = 6'(s);
        set_min   = 6'(mi);
        set_hour  = 5'(h);
        set_day   = 5'(d);
        set_month = 4'(mo);
        set_year  = 7'(y);
    endtask

    // Full handshake; err_out is set_err as seen in the cycle after CHECK.
    task automatic do_set(int s, int mi, int h, int d, int mo, int y, output bit err_out);
        drive_set(s, mi, h, d, mo, y);
        set_valid = 1'b1;
        cycle();
        set_valid = 1'b0;
        cycle();
        err_out = set_err;
        cycle();
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (tick_1hz !== 1'b1 && n < 3 * CLK_HZ);
        chk("tick_within_budget", int'(tick_1hz === 1'b1), 1);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mode_12h = 1'b0; set_valid = 1'b0;
        drive_set(0, 0, 0, 0, 0, 0);
        r_s = 0; r_mi = 0; r_h = 0; r_d = 1; r_mo = 1; r_y = 0;
        m_stage = 0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_second", int'(second), 0);
        chk("rst_day", int'(day), 1);
        chk("rst_month", int'(month), 1);
        chk("rst_year", int'(year), 0);
        chk("rst_set_ready", int'(set_ready), 1);
        chk("rst_tick", int'(tick_1hz), 0);

        // Free run: one tick every CLK_HZ cycles, then hold while stopped.
        run = 1'b1;
        n_ticks = 0;
        repeat (12) cycle();
        chk("ticks_in_12", n_ticks, 3);
        chk("second_after_3", int'(second), 3);
        run = 1'b0;
        n_ticks = 0;
        repeat (10) cycle();
        chk("ticks_stopped", n_ticks, 0);
        chk("second_held", int'(second), 3);
        run = 1'b1;
        repeat (3) cycle();
        chk("no_tick_resume", n_ticks, 0);
        cycle();
        chk("tick_resume", int'(tick_1hz), 1);
        chk("second_resume", int'(second), 4);

        // Day/month rollover, common year and leap year.
        run = 1'b0;
        do_set(59, 59, 23, 28, 2, 1, err_seen);
        run = 1'b1;
        wait_tick(waited);
        chk("feb28_hour", int'(hour), 0);
        chk("feb28_day", int'(day), 1);
        chk("feb28_month", int'(month), 3);
        chk("feb28_roll", int'(day_roll), 1);
        run = 1'b0;
        do_set(59, 59, 23, 28, 2, 4, err_seen);
        run = 1'b1;
        wait_tick(waited);
        chk("leap_day", int'(day), 29);
        chk("leap_month", int'(month), 2);
        chk("leap_roll", int'(day_roll), 1);

        // Century rollover.
        run = 1'b0;
        do_set(59, 59, 23, 31, 12, 99, err_seen);
        run = 1'b1;
        wait_tick(waited);
        run = 1'b0;
        chk("wrap_sec", int'(second), 0);
        chk("wrap_day", int'(day), 1);
        chk("wrap_month", int'(month), 1);
        chk("wrap_year", int'(year), 0);
        chk("wrap_roll", int'(day_roll), 1);
        chk("wrap_pulse", int'(year_wrap), 1);

        // Rejected requests leave the time untouched.
        do_set(0, 0, 0, 30, 2, 4, err_seen);
        chk("rej_feb30_err", int'(err_seen), 1);
        chk("rej_feb30_ready", int'(set_ready), 1);
        chk("rej_feb30_err_gone", int'(set_err), 0);
        chk("rej_feb30_day", int'(day), 1);
        do_set(0, 0, 24, 1, 1, 0, err_seen);
        chk("rej_h24_err", int'(err_seen), 1);
        chk("rej_h24_hour", int'(hour), 0);

        // APPLY lands on a prescaler wrap: the wrap is discarded.
        run = 1'b1;
        wait_tick(waited);
        cycle();
        drive_set(10, 20, 8, 15, 6, 42);
        set_valid = 1'b1;
        cycle();
        set_valid = 1'b0;
        cycle();
        cycle();
        chk("apply_no_tick", int'(tick_1hz), 0);
        chk("apply_sec", int'(second), 10);
        chk("apply_min", int'(minute), 20);
        chk("apply_hour", int'(hour), 8);
        wait_tick(waited);
        chk("tick_after_apply", waited, CLK_HZ);
        chk("apply_sec_next", int'(second), 11);

        // Reset during CHECK aborts the request.
        run = 1'b0;
        drive_set(30, 20, 10, 15, 6, 50);
        set_valid = 1'b1;
        cycle();
        set_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        chk("abort_hour", int'(hour), 0);
        chk("abort_sec", int'(second), 0);
        chk("abort_month", int'(month), 1);
        chk("abort_ready", int'(set_ready), 1);

        // 12/24-hour display mapping.
        vecs[0] = '{hour: 0,  mode: 1'b1, disp: 12, pm: 1'b0};
        vecs[1] = '{hour: 11, mode: 1'b1, disp: 11, pm: 1'b0};
        vecs[2] = '{hour: 12, mode: 1'b1, disp: 12, pm: 1'b1};
        vecs[3] = '{hour: 13, mode: 1'b1, disp: 1,  pm: 1'b1};
        vecs[4] = '{hour: 23, mode: 1'b1, disp: 11, pm: 1'b1};
        vecs[5] = '{hour: 0,  mode: 1'b0, disp: 0,  pm: 1'b0};
        vecs[6] = '{hour: 13, mode: 1'b0, disp: 13, pm: 1'b1};
        vecs[7] = '{hour: 23, mode: 1'b0, disp: 23, pm: 1'b1};
        for (int i = 0; i < 8; i++) begin
            do_set(0, 0, vecs[i].hour, 1, 1, 0, err_seen);
            mode_12h = vecs[i].mode;
            #1;
            chk($sformatf("disp_h%0d_m%0d", vecs[i].hour, vecs[i].mode),
                int'(disp_hour), vecs[i].disp);
            chk($sformatf("pm_h%0d", vecs[i].hour), int'(pm), int'(vecs[i].pm));
        end

        // Randomized traffic biased towards rollover boundaries.
        for (int i = 0; i < 3000; i++) begin
            run       = ($urandom_range(0, 9) != 0);
            mode_12h  = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 499) == 0);
            set_valid = ($urandom_range(0, 14) == 0);
            ry  = ($urandom_range(0, 3) == 0) ? 99 : int'($urandom_range(0, 99));
            rmo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                : (($urandom_range(0, 1) == 0) ? 12 : int'($urandom_range(1, 12)));
            rd  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                : dim(rmo, ry) - int'($urandom_range(0, 1));
            rh  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : 23;
            rmi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : 59;
            rs  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                : int'($urandom_range(57, 59));
            drive_set(rs, rmi, rh, rd, rmo, ry);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_calendar_core.md
Name: rtc_calendar_core

Overview:
Parametrised successor to the current time source. It keeps seconds, minutes, hours, day, month and year, with correct month lengths and leap years. It also provides run/stop control, a validated set-time handshake and a 12/24-hour display mode. Its outputs feed the bin2BCD converters and the LCD string formatter.

Parameters:
CLK_HZ, 50000000, input clock frequency; the prescaler divides by this value to make the 1 Hz tick.
YEAR_W, 7, year width; the year counts 0..99 and represents 2000..2099.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
run  in  1  1 = timekeeping advances; 0 = prescaler and time frozen
mode_12h  in  1  1 = disp_hour and pm use the 12-hour convention
set_valid  in  1  set request
set_ready  out  1  block can accept a set request
set_sec  in  6  requested second, binary
set_min  in  6  requested minute, binary
set_hour  in  5  requested hour, always 24-hour binary
set_day  in  5  requested day
set_month  in  4  requested month
set_year  in  YEAR_W  requested year
set_err  out  1  one-cycle pulse: request rejected
second  out  6  0..59
minute  out  6  0..59
hour  out  5  0..23
disp_hour  out  5  0..23 in 24-hour mode; 1..12 in 12-hour mode
pm  out  1  1 when hour >= 12 (valid in both modes)
day  out  5  1..28/29/30/31
month  out  4  1..12
year  out  YEAR_W  0..99
tick_1hz  out  1  one-cycle pulse on each second advance
day_roll  out  1  one-cycle pulse when the date increments
year_wrap  out  1  one-cycle pulse on the 99 -> 00 year rollover

Behaviour:
- Reset (rst=1 at a clk edge), all outputs:
  - time 00:00:00, date day=1, month=1, year=0
  - prescaler 0; FSM in IDLE
  - set_ready=1 in IDLE, so 1 after reset
  - set_err, tick_1hz, day_roll, year_wrap = 0
- Reset mid-handshake aborts the request; nothing is loaded.
- Prescaler:
  - Counts 0..CLK_HZ-1 only while run=1, then wraps to 0.
  - On the wrap cycle, the time advances by 1 s and tick_1hz=1 in the same registered cycle as the new second value.
  - run=0 holds both the prescaler and the time; there is no tick.
- Carry chain, all updated on a single edge:
  - sec 59 -> 0 carries to minute; min 59 -> 0 carries to hour; hour 23 -> 0 carries to date and pulses day_roll.
  - Day wraps to 1 after days_in_month(month, year); the month then increments.
  - Month 12 -> 1 increments year; year 99 -> 0 pulses year_wrap.
  - Leap year: year[1:0]==0, so February has 29 days (year 0 = 2000 is a leap year).
- Set FSM, states IDLE, CHECK, APPLY, REJECT:
  - IDLE: set_ready=1. When set_valid=1, capture all set_* fields and go to CHECK. set_valid outside IDLE is ignored.
  - CHECK: set_ready=0. Register validity:
    - sec <= 59, min <= 59, hour <= 23
    - 1 <= month <= 12
    - 1 <= day <= days_in_month(set_month, set_year)
  - Valid -> APPLY; invalid -> REJECT.
  - APPLY: load all six fields and clear the prescaler to 0. No tick is generated in this cycle; a coincident prescaler wrap is discarded. Go to IDLE.
  - REJECT: set_err=1 for this one cycle; time is unchanged. Go to IDLE.
- Set latency:
  - Request accepted at edge N; loaded values are visible after edge N+2; set_ready returns to 1 after edge N+2.
  - The first tick after a set comes CLK_HZ cycles after APPLY, provided run=1.
  - Ticks during CHECK advance time normally; APPLY then overwrites them.
- 12-hour mapping, combinational from registered hour:
  - hour 0 -> disp 12, pm=0
  - hour 1..11 -> same value, pm=0
  - hour 12 -> 12, pm=1
  - hour 13..23 -> hour-12, pm=1
- mode_12h affects disp_hour only; it takes effect immediately.

Decomposition:
- Package rtc_pkg holds:
  - the FSM state enum (IDLE/CHECK/APPLY/REJECT)
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MONTH_MAX=12
  - function is_leap(year)
  - function days_in_month(month, year), using the 31/28-29/31/30/31/30/31/31/30/31/30/31 table; returns 0 for an invalid month
- Sub-module rtc_prescaler (parameter CLK_HZ; ports clk, rst, en, clr, tick) isolates the divider so benches can override CLK_HZ=4.

Test Plan:
- CLK_HZ=4, run=1 from reset -> tick_1hz every 4th cycle; second=1 after the first tick; run=0 for 10 cycles produces no tick, with the prescaler held.
- Set 23:59:59, 28-Feb, year 1; one tick -> 00:00:00, 1-Mar, day_roll=1. Same with year 4 -> 29-Feb.
- Set 23:59:59, 31-Dec, year 99; one tick -> 00:00:00, 1-Jan, year 0, with day_roll=1 and year_wrap=1 in the same cycle.
- Set 30-Feb year 4, and separately hour=24 -> set_err pulses once in the REJECT cycle; all outputs unchanged; set_ready back to 1 two cycles after acceptance.
- Valid set accepted on the prescaler's wrap-1 cycle -> no extra increment; values equal the set fields; next tick comes exactly 4 cycles after APPLY. rst asserted in CHECK -> no load; outputs at reset values.
- mode_12h=1 sweeping hour 0/11/12/13/23 -> disp_hour 12/11/12/1/11 and pm 0/0/1/1/1.
